// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the memory arbiter.
// Optional urgent-requester mode is selected with MEM_ARB_PRIO_EN.
package mem_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

    localparam int DEF_AW = 6;
    localparam int DEF_DW = 14;

    // A burst limit of 1 still needs a one-bit counter to keep the vector legal.
    function automatic int cnt_width(input int max_burst);
        return (max_burst > 1) ? $clog2(max_burst) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational round-robin picker: lowest requester at or above ptr wins,
// otherwise the lowest requester overall.
module mem_arbiter_rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] win_oh,
    output logic [IW-1:0]   win_idx,
    output logic            any_req
);

    logic [NREQ-1:0] hi_req;
    logic [NREQ-1:0] sel_req;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_mask
        assign hi_req[gi] = req[gi] && (IW'(gi) >= ptr);
    end

    assign any_req = |req;

    always_comb begin
        sel_req = (|hi_req) ? hi_req : req;
        win_idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (sel_req[i]) begin
                win_idx = IW'(i);
            end
        end
        win_oh = '0;
        if (any_req) begin
            win_oh[win_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous memory among NREQ requesters.
// Define MEM_ARB_PRIO_EN to make requester 0 urgent (preempting, no burst limit).
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int AW        = DEF_AW,
    parameter int DW        = DEF_DW,
    parameter int MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      we,
    input  logic [NREQ*AW-1:0]   addr,
    input  logic [NREQ*DW-1:0]   wdata,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      rvalid,
    output logic [DW-1:0]        rdata,
    output logic                 busy,
    output logic                 mem_cs,
    output logic                 mem_we,
    output logic [AW-1:0]        mem_addr,
    output logic [DW-1:0]        mem_din,
    input  logic [DW-1:0]        mem_dout
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = cnt_width(MAX_BURST);
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);
    localparam logic [NREQ-1:0] REQ0_OH = {{(NREQ-1){1'b0}}, 1'b1};

    arb_state_t      state_reg, state_next;
    logic [IW-1:0]   owner_reg, owner_next;
    logic [IW-1:0]   ptr_reg, ptr_next;
    logic [CW-1:0]   count_reg, count_next;
    logic [NREQ-1:0] gnt_reg, gnt_next;
    logic            rd_pend_reg;
    logic [IW-1:0]   rd_owner_reg;

    logic [AW-1:0]   addr_arr  [NREQ];
    logic [DW-1:0]   wdata_arr [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign addr_arr[gi]  = addr[gi*AW +: AW];
        assign wdata_arr[gi] = wdata[gi*DW +: DW];
    end

    logic            beat;
    logic            urgent_owner;
    logic [IW-1:0]   owner_inc;
    logic [NREQ-1:0] pick_req;
    logic [IW-1:0]   pick_ptr;
    logic [NREQ-1:0] win_oh;
    logic [IW-1:0]   win_idx;
    logic            pick_any;

    assign beat      = (state_reg == ST_BUSY) && req[owner_reg] && gnt_reg[owner_reg];
    assign owner_inc = (owner_reg == IW'(NREQ - 1)) ? '0 : owner_reg + 1'b1;

`ifdef MEM_ARB_PRIO_EN
    assign urgent_owner = (owner_reg == '0);
`else
    assign urgent_owner = 1'b0;
`endif

    // While busy only the other requesters compete; the urgent owner keeps the old pointer.
    assign pick_req = (state_reg == ST_BUSY) ? (req & ~gnt_reg) : req;
    assign pick_ptr = ((state_reg == ST_BUSY) && !urgent_owner) ? owner_inc : ptr_reg;

    mem_arbiter_rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .req     (pick_req),
        .ptr     (pick_ptr),
        .win_oh  (win_oh),
        .win_idx (win_idx),
        .any_req (pick_any)
    );

    always_comb begin
        state_next = state_reg;
        owner_next = owner_reg;
        ptr_next   = ptr_reg;
        count_next = count_reg;
        gnt_next   = gnt_reg;
        unique case (state_reg)
            ST_IDLE: begin
                if (pick_any) begin
                    state_next = ST_BUSY;
                    owner_next = win_idx;
                    gnt_next   = win_oh;
                    count_next = '0;
`ifdef MEM_ARB_PRIO_EN
                    if (req[0]) begin
                        owner_next = '0;
                        gnt_next   = REQ0_OH;
                    end
`endif
                end
            end
            ST_BUSY: begin
                if (!req[owner_reg]) begin
                    count_next = '0;
                    ptr_next   = urgent_owner ? ptr_reg : owner_inc;
                    if (pick_any) begin
                        owner_next = win_idx;
                        gnt_next   = win_oh;
                    end else begin
                        state_next = ST_IDLE;
                        gnt_next   = '0;
                    end
                end else if (urgent_owner) begin
                    count_next = '0;
                end else if (count_reg == CNT_LAST) begin
                    count_next = '0;
                    if (pick_any) begin
                        owner_next = win_idx;
                        gnt_next   = win_oh;
                        ptr_next   = owner_inc;
                    end
                end else begin
                    count_next = count_reg + 1'b1;
                end
`ifdef MEM_ARB_PRIO_EN
                if (req[0] && (owner_reg != '0)) begin
                    state_next = ST_BUSY;
                    owner_next = '0;
                    gnt_next   = REQ0_OH;
                    count_next = '0;
                    ptr_next   = ptr_reg;
                end
`endif
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            owner_reg    <= '0;
            ptr_reg      <= '0;
            count_reg    <= '0;
            gnt_reg      <= '0;
            rd_pend_reg  <= 1'b0;
            rd_owner_reg <= '0;
        end else begin
            state_reg    <= state_next;
            owner_reg    <= owner_next;
            ptr_reg      <= ptr_next;
            count_reg    <= count_next;
            gnt_reg      <= gnt_next;
            rd_pend_reg  <= beat && !we[owner_reg];
            rd_owner_reg <= owner_reg;
        end
    end

    assign mem_cs   = beat;
    assign mem_we   = beat && we[owner_reg];
    assign mem_addr = addr_arr[owner_reg];
    assign mem_din  = wdata_arr[owner_reg];
    assign gnt      = gnt_reg;
    assign busy     = (state_reg == ST_BUSY);

    // A read return still in flight when reset arrives is suppressed immediately.
    always_comb begin
        rvalid = '0;
        if (rd_pend_reg && !rst) begin
            rvalid[rd_owner_reg] = 1'b1;
        end
    end

    assign rdata = (rd_pend_reg && !rst) ? mem_dout : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a rule-level model predicts each cycle,
// expectations are queued and a negedge monitor compares them with the DUT.
module tb_mem_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 6;
    localparam int DW   = 14;
    localparam int MB   = 4;
`ifdef MEM_ARB_PRIO_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req, we;
    logic [NREQ*AW-1:0]  addr;
    logic [NREQ*DW-1:0]  wdata;
    logic [NREQ-1:0]     gnt, rvalid;
    logic [DW-1:0]       rdata;
    logic                busy, mem_cs, mem_we;
    logic [AW-1:0]       mem_addr;
    logic [DW-1:0]       mem_din;
    logic [DW-1:0]       mem_dout = '0;
    logic [DW-1:0]       tb_mem [64];

    always #5 clk = ~clk;

    mem_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .busy(busy),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout)
    );

    // Single-port memory with one-cycle read latency
    always @(posedge clk) begin
        if (mem_cs) begin
            if (mem_we) tb_mem[mem_addr] <= mem_din;
            else        mem_dout <= tb_mem[mem_addr];
        end
    end

    typedef struct { logic [NREQ-1:0] gnt; logic busy; logic cs; logic mwe;
                     logic [NREQ-1:0] rvalid; logic chk_rdata; } cyc_t;
    typedef struct { logic we; logic [AW-1:0] addr; logic [DW-1:0] din; } beat_t;
    typedef struct { logic [NREQ-1:0] rv; logic [DW-1:0] data; } rd_t;

    cyc_t  q_cyc[$];
    beat_t q_beat[$];
    rd_t   q_rd[$];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model state
    int            m_busy, m_owner, m_ptr, m_cnt, m_rdowner;
    bit            m_rdpend;
    logic [DW-1:0] m_rddata;
    logic [DW-1:0] ref_mem [64];
    int            beat_owner;
    int            rem [NREQ];

    function automatic int pick(input logic [NREQ-1:0] r, input int start);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(start + k) % NREQ]) return (start + k) % NREQ;
        end
        return 0;
    endfunction

    // Predict this cycle's outputs, then advance the model across the clock edge.
    task automatic step();
        cyc_t c;
        int o;
        bit b;
        logic [NREQ-1:0] oth, o_oh, rd_oh;
        logic [AW-1:0] a;
        o = m_owner;
        b = (m_busy != 0) && req[o];
        o_oh = '0;
        o_oh[o] = 1'b1;
        rd_oh = '0;
        rd_oh[m_rdowner] = 1'b1;
        a = addr[o*AW +: AW];
        c.gnt = (m_busy != 0) ? o_oh : '0;
        c.busy = (m_busy != 0);
        c.cs = b;
        c.mwe = b && we[o];
        c.rvalid = (m_rdpend && !rst) ? rd_oh : '0;
        c.chk_rdata = rst;
        q_cyc.push_back(c);
        if (b) q_beat.push_back('{we[o], a, wdata[o*DW +: DW]});
        if (m_rdpend && !rst) q_rd.push_back('{rd_oh, m_rddata});
        beat_owner = b ? o : -1;
        if (b && we[o])  ref_mem[a] = wdata[o*DW +: DW];
        if (b && !we[o]) m_rddata = ref_mem[a];
        if (rst) begin
            m_busy = 0; m_owner = 0; m_ptr = 0; m_cnt = 0; m_rdpend = 0; m_rdowner = 0;
        end else begin
            m_rdpend = b && !we[o];
            m_rdowner = o;
            oth = req;
            oth[o] = 1'b0;
            if (m_busy == 0) begin
                if (req != '0) begin
                    m_busy = 1;
                    m_cnt = 0;
                    m_owner = (PRIO && req[0]) ? 0 : pick(req, m_ptr);
                end
            end else if (PRIO && o != 0 && req[0]) begin
                m_owner = 0;
                m_cnt = 0;
            end else if (!req[o]) begin
                m_cnt = 0;
                if (!(PRIO && o == 0)) m_ptr = (o + 1) % NREQ;
                if (oth != '0) m_owner = pick(oth, m_ptr);
                else m_busy = 0;
            end else if (PRIO && o == 0) begin
                m_cnt = 0;
            end else if (m_cnt == MB - 1) begin
                m_cnt = 0;
                if (oth != '0) begin
                    m_ptr = (o + 1) % NREQ;
                    m_owner = pick(oth, m_ptr);
                end
            end else begin
                m_cnt++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input bit r, input bit w, input int a, input int d);
        req[i] = r;
        we[i] = w;
        addr[i*AW +: AW] = AW'(a);
        wdata[i*DW +: DW] = DW'(d);
    endtask

    task automatic rand_port(input int i);
        we[i] = 1'($urandom_range(0, 1));
        addr[i*AW +: AW] = AW'($urandom_range(0, 15));
        wdata[i*DW +: DW] = DW'($urandom);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        step();
        rst = 1'b0;
    endtask

    // Monitor: pops expectations whenever the DUT presents the matching output
    cyc_t  mc;
    beat_t mb;
    rd_t   mr;
    always @(negedge clk) begin
        if (q_cyc.size() > 0) begin
            mc = q_cyc.pop_front();
            chk("gnt", gnt, mc.gnt);
            chk("busy", busy, mc.busy);
            chk("mem_cs", mem_cs, mc.cs);
            chk("mem_we", mem_we, mc.mwe);
            chk("rvalid", rvalid, mc.rvalid);
            if (mc.chk_rdata) chk("rdata_reset", rdata, 0);
        end
        if (mem_cs) begin
            if (q_beat.size() == 0) chk("beat_unexpected", 1, 0);
            else begin
                mb = q_beat.pop_front();
                chk("beat_we", mem_we, mb.we);
                chk("beat_addr", mem_addr, mb.addr);
                if (mb.we) chk("beat_din", mem_din, mb.din);
            end
        end
        if (rvalid != '0) begin
            if (q_rd.size() == 0) chk("rvalid_unexpected", 1, 0);
            else begin
                mr = q_rd.pop_front();
                chk("rd_strobe", rvalid, mr.rv);
                chk("rd_data", rdata, mr.data);
            end
        end
    end

    initial begin
        rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
        m_busy = 0; m_owner = 0; m_ptr = 0; m_cnt = 0; m_rdpend = 0; m_rdowner = 0;
        m_rddata = '0; beat_owner = -1;
        for (int i = 0; i < 64; i++) begin
            tb_mem[i] = DW'(i * 37 + 11);
            ref_mem[i] = DW'(i * 37 + 11);
        end
        tb_mem[10] = 14'h0123;
        ref_mem[10] = 14'h0123;
        @(posedge clk);
        #1;
        step();
        step();
        rst = 1'b0;

        // Single write beat, then release
        drive(1, 1, 1, 'h05, 'h1ABC);
        step();
        #1;
        chk("t1_gnt", gnt, 4'b0010);
        chk("t1_cs", mem_cs, 1);
        chk("t1_we", mem_we, 1);
        chk("t1_addr", mem_addr, 6'h05);
        chk("t1_din", mem_din, 14'h1ABC);
        step();
        req[1] = 1'b0;
        step();
        #1;
        chk("t1_gnt_off", gnt, 0);
        chk("t1_busy_off", busy, 0);
        step();

        // Single read beat and its return strobe
        drive(2, 1, 0, 'h0A, 0);
        step();
        step();
        req[2] = 1'b0;
        #1;
        chk("t2_rvalid", rvalid, 4'b0100);
        chk("t2_rdata", rdata, 14'h0123);
        step();
        #1;
        chk("t2_rvalid_pulse", rvalid, 0);
        step();

        // All four requesting: 4-beat bursts rotating 0,1,2,3,0
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            drive(i, 1, 1'(i & 1), 16 + i, 'h100 + i);
        end
        step();
        for (int k = 0; k < 20; k++) begin
            #1;
            chk("t3_gnt", gnt, 32'(1) << ((k / 4) % 4));
            chk("t3_cs", mem_cs, 1);
            step();
        end
        req = '0;
        step();
        step();

        // Lone requester is never cut off
        do_reset();
        drive(3, 1, 0, 'h07, 0);
        step();
        for (int k = 0; k < 10; k++) begin
            #1;
            chk("t4_gnt", gnt, 4'b1000);
            chk("t4_cs", mem_cs, 1);
            step();
        end
        req = '0;
        step();
        step();

        // Reset right after a read beat drops the return
        drive(1, 1, 0, 'h03, 0);
        step();
        step();
        req[1] = 1'b0;
        rst = 1'b1;
        #1;
        chk("t5_rvalid_rst", rvalid, 0);
        step();
        rst = 1'b0;
        #1;
        chk("t5_rvalid", rvalid, 0);
        chk("t5_gnt", gnt, 0);
        chk("t5_busy", busy, 0);
        step();

        // Requester 0 arrives during another requester's burst
        do_reset();
        drive(2, 1, 1, 'h0C, 'h2222);
        step();
        step();
        drive(0, 1, 0, 'h0A, 0);
        step();
        #1;
        chk("t6_gnt", gnt, PRIO ? 4'b0001 : 4'b0100);
        for (int k = 0; k < 4; k++) step();
        req[0] = 1'b0;
        for (int k = 0; k < 3; k++) step();
        req[2] = 1'b0;
        step();
        step();

        // Request withdrawn as the grant rises: no beat, release
        do_reset();
        drive(1, 1, 1, 'h09, 'h0555);
        step();
        req[1] = 1'b0;
        #1;
        chk("t7_no_beat", mem_cs, 0);
        step();
        step();

        // Randomized traffic
        do_reset();
        for (int i = 0; i < NREQ; i++) rem[i] = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst = ($urandom_range(0, 299) == 0);
            step();
            if (beat_owner >= 0) begin
                rem[beat_owner]--;
                if (rem[beat_owner] == 0) req[beat_owner] = 1'b0;
                rand_port(beat_owner);
            end
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i] && rem[i] == 0 && beat_owner != i && $urandom_range(0, 3) == 0) begin
                    rem[i] = $urandom_range(1, 7);
                    req[i] = 1'b1;
                    rand_port(i);
                end
            end
        end
        rst = 1'b0;
        req = '0;
        step();
        step();
        step();
        @(negedge clk);
        #1;
        chk("beat_queue_drained", q_beat.size(), 0);
        chk("read_queue_drained", q_rd.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
